// File: rtl/inq_ary_rd_port.sv
// inq_ary_rd_port: read-side port for the inbound-queue array, with single-entry reads and full-array scans
module inq_ary_rd_port #(
    parameter int ADDR_W  = 4,
    parameter int ENTRY_W = 2
) (
    input  logic                              clk,
    input  logic                              reset_r,
    input  logic [ENTRY_W-1:0]                inq_ary0 [2**ADDR_W],
    input  logic                              rd_req,
    input  logic [ADDR_W-1:0]                 rd_addr,
    output logic                              rd_rdy,
    output logic                              rd_vld,
    output logic [ENTRY_W-1:0]                rd_data,
    output logic [ADDR_W-1:0]                 rd_data_addr,
    input  logic                              rd_ack,
    input  logic                              scan_start,
    output logic                              scan_busy,
    output logic                              scan_done,
    output logic [(2**ADDR_W)*ENTRY_W-1:0]    scan_word
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {INIT, IDLE, RD_HOLD, SCAN} state_t;

    state_t                     state, state_nxt;
    logic                       scan_pend, pend_nxt;
    logic                       fire, last;
    logic                       rdy_nxt, vld_nxt, busy_nxt;
    logic [ADDR_W-1:0]          idx;
    logic [DEPTH*ENTRY_W-1:0]   shadow, shadow_nxt;

    assign fire = rd_req & rd_rdy;
    assign last = (state == SCAN) && (idx == '1);

    always_ff @(posedge clk or posedge reset_r) begin
        if (reset_r)
            state <= INIT;
        else
            state <= state_nxt;
    end

    // A read handshake beats a simultaneous scan request; the scan is parked in scan_pend
    always_comb begin
        state_nxt = state == INIT    ? IDLE :
                    state == IDLE    ? (fire ? RD_HOLD : (scan_pend | scan_start) ? SCAN : IDLE) :
                    state == RD_HOLD ? (rd_ack ? IDLE : RD_HOLD) :
                                       (last ? IDLE : SCAN);
        pend_nxt  = last ? 1'b0 :
                    ((state == IDLE && fire && scan_start) || (state == RD_HOLD && scan_start)) ? 1'b1 :
                    scan_pend;
    end

    always_comb begin
        rdy_nxt    = (state_nxt == IDLE) && !pend_nxt;
        vld_nxt    = state_nxt == RD_HOLD;
        busy_nxt   = state_nxt == SCAN;
        shadow_nxt = shadow;
        shadow_nxt[int'(idx)*ENTRY_W +: ENTRY_W] = inq_ary0[idx];
    end

    always_ff @(posedge clk or posedge reset_r) begin
        if (reset_r) begin
            scan_pend    <= 1'b0;
            rd_rdy       <= 1'b0;
            rd_vld       <= 1'b0;
            rd_data      <= '0;
            rd_data_addr <= '0;
            scan_busy    <= 1'b0;
            scan_done    <= 1'b0;
            scan_word    <= '0;
            shadow       <= '0;
            idx          <= '0;
        end else begin
            scan_pend <= pend_nxt;
            rd_rdy    <= rdy_nxt;
            rd_vld    <= vld_nxt;
            scan_busy <= busy_nxt;
            scan_done <= last;
            if (fire) begin
                rd_data      <= inq_ary0[rd_addr];
                rd_data_addr <= rd_addr;
            end
            if (state == SCAN) begin
                shadow <= shadow_nxt;
                idx    <= idx + 1'b1;
            end
            if (last)
                scan_word <= shadow_nxt;
        end
    end
endmodule

// File: tb/tb_inq_ary_rd_port.sv
// tb_inq_ary_rd_port: directed checks of reads, scans, collisions and async reset
module tb_inq_ary_rd_port;
    logic        clk = 0;
    logic        reset_r;
    logic [1:0]  arr [16];
    logic        rd_req, rd_ack, scan_start;
    logic [3:0]  rd_addr;
    logic        rd_rdy, rd_vld, scan_busy, scan_done;
    logic [1:0]  rd_data;
    logic [3:0]  rd_data_addr;
    logic [31:0] scan_word;
    int          errors = 0;
    int          checks = 0;

    inq_ary_rd_port dut (
        .clk(clk), .reset_r(reset_r), .inq_ary0(arr),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy), .rd_vld(rd_vld),
        .rd_data(rd_data), .rd_data_addr(rd_data_addr), .rd_ack(rd_ack),
        .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done),
        .scan_word(scan_word)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        reset_r = 1; rd_req = 0; rd_ack = 0; scan_start = 0; rd_addr = 0;
        for (int i = 0; i < 16; i++) arr[i] = 2'b00;
        step(2);
        chk("rst_rdy", 32'(rd_rdy), 0);
        chk("rst_vld", 32'(rd_vld), 0);
        chk("rst_busy", 32'(scan_busy), 0);
        chk("rst_done", 32'(scan_done), 0);
        chk("rst_data", 32'(rd_data), 0);
        chk("rst_word", scan_word, 0);
        reset_r = 0;
        step(2);
        chk("rdy_after_init", 32'(rd_rdy), 1);

        arr[5] = 2'b10; rd_req = 1; rd_addr = 5;
        step(1);
        rd_req = 0;
        chk("rd_vld", 32'(rd_vld), 1);
        chk("rd_data", 32'(rd_data), 2);
        chk("rd_addr", 32'(rd_data_addr), 5);
        chk("rd_rdy_busy", 32'(rd_rdy), 0);
        arr[5] = 2'b01;
        step(4);
        chk("hold_data", 32'(rd_data), 2);
        chk("hold_vld", 32'(rd_vld), 1);
        rd_ack = 1;
        step(1);
        rd_ack = 0;
        chk("ack_vld", 32'(rd_vld), 0);
        chk("ack_rdy", 32'(rd_rdy), 1);
        chk("data_kept", 32'(rd_data), 2);

        for (int i = 0; i < 16; i++) arr[i] = 2'(i);
        scan_start = 1;
        step(1);
        scan_start = 0; rd_req = 1; rd_addr = 3;
        chk("scan_busy_start", 32'(scan_busy), 1);
        for (int k = 1; k < 16; k++) begin
            scan_start = (k == 5);
            step(1);
            chk("scan_busy_mid", 32'(scan_busy), 1);
            chk("scan_done_mid", 32'(scan_done), 0);
            chk("scan_rd_ignored", 32'(rd_vld), 0);
        end
        scan_start = 0;
        step(1);
        rd_req = 0;
        chk("scan_busy_end", 32'(scan_busy), 0);
        chk("scan_done", 32'(scan_done), 1);
        chk("scan_word", scan_word, 32'hE4E4E4E4);
        step(1);
        chk("done_pulse", 32'(scan_done), 0);
        chk("word_held", scan_word, 32'hE4E4E4E4);
        chk("no_read_after_scan", 32'(rd_vld), 0);
        step(2);
        chk("no_extra_scan", 32'(scan_busy), 0);

        arr[9] = 2'b11; rd_req = 1; rd_addr = 9; scan_start = 1;
        step(1);
        rd_req = 0; scan_start = 0;
        chk("col_vld", 32'(rd_vld), 1);
        chk("col_data", 32'(rd_data), 3);
        chk("col_addr", 32'(rd_data_addr), 9);
        chk("col_busy", 32'(scan_busy), 0);
        rd_ack = 1;
        step(1);
        rd_ack = 0;
        chk("col_ack_vld", 32'(rd_vld), 0);
        chk("col_rdy_pend", 32'(rd_rdy), 0);
        n = 0;
        while (!scan_done && n < 40) begin
            step(1);
            n++;
        end
        chk("col_done_latency", 32'(n), 17);
        chk("col_word", scan_word, 32'hE4ECE4E4);
        chk("col_rdy_after", 32'(rd_rdy), 1);

        scan_start = 1;
        step(1);
        scan_start = 0;
        step(7);
        #2 reset_r = 1;
        #1;
        chk("arst_busy", 32'(scan_busy), 0);
        chk("arst_done", 32'(scan_done), 0);
        chk("arst_vld", 32'(rd_vld), 0);
        chk("arst_word", scan_word, 0);
        @(negedge clk);
        reset_r = 0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (scan_done || scan_busy) seen = 1;
        end
        chk("arst_no_done", 32'(seen), 0);
        chk("arst_rdy", 32'(rd_rdy), 1);

        rd_ack = 1;
        step(1);
        rd_ack = 0;
        chk("stray_ack_rdy", 32'(rd_rdy), 1);
        chk("stray_ack_vld", 32'(rd_vld), 0);
        chk("stray_ack_busy", 32'(scan_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inq_ary_rd_port.md
# inq_ary_rd_port

Read-side port for the 16-entry × 2-bit inbound-queue array `inq_ary0`, which the write-side register file fills with `{wr_data[4], wr_data[0]}`. The block serves single-entry reads through a valid/ack handshake. It also performs a full-array scan that returns all 16 entries as one packed snapshot word. It sits between the array storage and the consumer logic, and it never writes the array.

## Interface
- `ADDR_W`, 4, entry address width; depth is fixed at 2**ADDR_W = 16
- `ENTRY_W`, 2, bits per entry
- `clk` in 1: single clock, rising edge
- `reset_r` in 1: asynchronous, active-high reset
- `inq_ary0` in [ENTRY_W-1:0] x 16: array contents from the write side
- `rd_req` in 1: read request
- `rd_addr` in ADDR_W: entry to read, sampled with `rd_req`
- `rd_rdy` out 1: registered; block accepts `rd_req`
- `rd_vld` out 1: `rd_data`/`rd_data_addr` valid
- `rd_data` out ENTRY_W: captured entry
- `rd_data_addr` out ADDR_W: address `rd_data` came from
- `rd_ack` in 1: consumer accepts `rd_data`
- `scan_start` in 1: request a full-array scan (pulse)
- `scan_busy` out 1: scan in progress
- `scan_done` out 1: one-cycle pulse when `scan_word` is updated
- `scan_word` out 16*ENTRY_W: entry i at bits [2i+1:2i]

## Operation
- States:
  - INIT (reset value)
  - IDLE
  - RD_HOLD
  - SCAN
- INIT → IDLE unconditionally on the first edge after reset release.
- Reset values:
  - All outputs are 0, including `rd_rdy`.
  - `scan_pend` is 0.
  - The scan index is 0 and the shadow word is 0.
- `rd_rdy` is 1 only in IDLE with `scan_pend`=0. It is registered from the next-state value.
- Read handshake: `rd_req & rd_rdy` at an edge performs these actions at that edge:
  - `rd_data` ← `inq_ary0[rd_addr]`
  - `rd_data_addr` ← `rd_addr`
  - `rd_vld` ← 1, `rd_rdy` ← 0
  - state → RD_HOLD
- RD_HOLD:
  - `rd_data` and `rd_data_addr` are held stable.
  - On `rd_ack`: `rd_vld` ← 0 and state → IDLE.
  - `rd_rdy` returns to 1 unless `scan_pend` is set.
- `rd_ack` with `rd_vld`=0 is ignored.
- `rd_req` is ignored when `rd_rdy`=0; no request is queued.
- `rd_data` keeps its last value after `rd_vld` falls.
- Scan entry:
  - From IDLE, SCAN is entered when `scan_pend` is set, or when `scan_start` is high and the read handshake is not firing.
  - If `scan_start` and a read handshake occur at the same edge, the read wins and `scan_pend` ← 1.
  - `scan_start` in RD_HOLD sets `scan_pend`.
  - `scan_start` in SCAN or INIT is ignored.
- SCAN:
  - `scan_busy` = 1.
  - Index i = 0..15 advances by one per cycle.
  - Each cycle, the shadow bits [2i+1:2i] ← `inq_ary0[i]`.
  - After i = 15: `scan_word` ← shadow, `scan_done` pulses for 1 cycle, `scan_pend` ← 0, `scan_busy` ← 0, state → IDLE.
- `scan_word` changes only on a `scan_done` edge. Partial results are never visible.
- The index wraps 15 → 0 only through completion.
- Asserting `reset_r` in any state aborts the operation immediately and applies all reset values, including `scan_word` = 0.

## Timing
- Read latency: `rd_req` sampled at edge E; `rd_vld` = 1 and data are valid after E.
- The sampled value is the array content visible before E. A same-edge write by the writer is not seen.
- Minimum read cycle is 2 clocks: `rd_ack` in the first `rd_vld` cycle gives `rd_rdy` = 1 again after the next edge.
- Scan latency: scan begins at edge S (entry into SCAN).
  - Entry i is sampled at edge S+1+i.
  - `scan_done` and the new `scan_word` appear after S+16.
  - `scan_busy` is high from S through S+16.
- Back-to-back scans: a scan pending during RD_HOLD starts on the edge after the IDLE return.
- There is no combinational path from `rd_req`, `rd_ack` or `scan_start` to any output.

## Test plan
- Reset, then release: the second edge shows `rd_rdy` = 1. With `inq_ary0[5]` = 2'b10, `rd_req` and `rd_addr` = 5 give `rd_vld` = 1, `rd_data` = 2'b10, `rd_data_addr` = 5 one cycle later.
- Hold `rd_ack` = 0 for 4 cycles while the writer changes `inq_ary0[5]` to 2'b01: `rd_data` stays 2'b10. Then `rd_ack` gives `rd_vld` = 0 and `rd_rdy` = 1 on the next cycle.
- Load `inq_ary0[i]` = i[1:0] and pulse `scan_start`: `scan_busy` is high for 16 cycles, then `scan_done` pulses with `scan_word` = 32'hE4E4E4E4. `rd_req` during the scan is ignored.
- Assert `rd_req` and `scan_start` on the same edge in IDLE: the read completes first and `rd_rdy` stays 0 after `rd_ack`. The scan then starts with `scan_done` 17 cycles later, after which `rd_rdy` = 1.
- Assert `reset_r` asynchronously at scan index 7: `scan_busy`, `scan_done`, `rd_vld` and `scan_word` go to 0 immediately. No `scan_done` follows after release.
- Pulse `rd_ack` while `rd_vld` = 0, and `scan_start` during SCAN: there is no state change and no extra scan.
